// File: rtl/rope_electro_sequencer.sv
// Rope electrification sequencer: picks one rope pseudo-randomly, shows it as
// WARN then LIVE for frame-counted windows, and turns a monkey touching the
// LIVE rope into a single-cycle shock event.
module rope_electro_sequencer #(
    parameter int unsigned ROPES       = 6,
    parameter int unsigned IDLE_FRAMES = 90,
    parameter int unsigned WARN_FRAMES = 30,
    parameter int unsigned LIVE_FRAMES = 60,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 enable,
    input  logic [ROPES-1:0]     monkeyCollision,
    output logic [ROPES*2-1:0]   electroStatus,
    output logic [2:0]           activeRope,
    output logic                 liveN,
    output logic                 shockPulse,
    output logic [2:0]           shockRope
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PICK = 2'd1,
        S_WARN = 2'd2,
        S_LIVE = 2'd3
    } state_t;

    localparam logic [6:0] IDLE_LAST = 7'(IDLE_FRAMES - 1);
    localparam logic [6:0] WARN_LAST = 7'(WARN_FRAMES - 1);
    localparam logic [6:0] LIVE_LAST = 7'(LIVE_FRAMES - 1);
    localparam logic [3:0] ROPES_W   = 4'(ROPES);
    localparam logic [2:0] LAST_ROPE = 3'(ROPES - 1);

    state_t     r_state,       w_state_nxt;
    logic [6:0] r_frame_cnt,   w_frame_cnt_nxt;
    logic [7:0] r_lfsr,        w_lfsr_nxt;
    logic [2:0] r_active_rope, w_active_rope_nxt;
    logic [2:0] r_prev_rope,   w_prev_rope_nxt;
    logic       r_shock_pulse, w_shock_pulse_nxt;
    logic [2:0] r_shock_rope,  w_shock_rope_nxt;

    logic [6:0] w_frame_last;
    logic       w_frame_done;
    logic [7:0] w_coll_pad;
    logic       w_hit;
    logic [3:0] w_raw;
    logic [3:0] w_folded;
    logic [2:0] w_pick;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running regardless of enable.
    assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    // Collision vector padded to 8 so any 3-bit rope index is in range.
    assign w_coll_pad = 8'(monkeyCollision);
    assign w_hit      = w_coll_pad[r_active_rope];

    // Terminal frame count for the current state.
    always_comb begin
        case (r_state)
            S_IDLE:  w_frame_last = IDLE_LAST;
            S_WARN:  w_frame_last = WARN_LAST;
            S_LIVE:  w_frame_last = LIVE_LAST;
            default: w_frame_last = '0;
        endcase
    end

    assign w_frame_done = startOfFrame && (r_frame_cnt == w_frame_last);

    // Rope choice: fold LFSR bits into range, then step past the previous rope.
    always_comb begin
        w_raw    = {1'b0, r_lfsr[2:0]};
        w_folded = (w_raw >= ROPES_W) ? (w_raw - ROPES_W) : w_raw;
        w_pick   = w_folded[2:0];
        if (w_folded == {1'b0, r_prev_rope}) begin
            w_pick = ((w_folded + 4'd1) == ROPES_W) ? 3'd0 : (w_folded[2:0] + 3'd1);
        end
    end

    // Next-state and registered-output logic for the sequencer FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_frame_cnt_nxt   = r_frame_cnt;
        w_active_rope_nxt = r_active_rope;
        w_prev_rope_nxt   = r_prev_rope;
        w_shock_pulse_nxt = 1'b0;
        w_shock_rope_nxt  = r_shock_rope;

        case (r_state)
            S_IDLE: begin
                if (enable && startOfFrame) begin
                    if (w_frame_done) begin
                        w_state_nxt     = S_PICK;
                        w_frame_cnt_nxt = '0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 7'd1;
                    end
                end
            end
            S_PICK: begin
                w_frame_cnt_nxt = '0;
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_active_rope_nxt = w_pick;
                    w_prev_rope_nxt   = w_pick;
                    w_state_nxt       = S_WARN;
                end
            end
            S_WARN: begin
                if (!enable) begin
                    w_state_nxt     = S_IDLE;
                    w_frame_cnt_nxt = '0;
                end else if (startOfFrame) begin
                    if (w_frame_done) begin
                        w_state_nxt     = S_LIVE;
                        w_frame_cnt_nxt = '0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 7'd1;
                    end
                end
            end
            S_LIVE: begin
                // Disable beats a shock; a shock beats the frame timer.
                if (!enable) begin
                    w_state_nxt     = S_IDLE;
                    w_frame_cnt_nxt = '0;
                end else if (w_hit) begin
                    w_shock_pulse_nxt = 1'b1;
                    w_shock_rope_nxt  = r_active_rope;
                    w_state_nxt       = S_IDLE;
                    w_frame_cnt_nxt   = '0;
                end else if (startOfFrame) begin
                    if (w_frame_done) begin
                        w_state_nxt     = S_IDLE;
                        w_frame_cnt_nxt = '0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 7'd1;
                    end
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_frame_cnt_nxt = '0;
            end
        endcase
    end

    // State and datapath registers; reset returns every output to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_frame_cnt   <= '0;
            r_lfsr        <= LFSR_SEED;
            r_active_rope <= '0;
            r_prev_rope   <= LAST_ROPE;
            r_shock_pulse <= 1'b0;
            r_shock_rope  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_lfsr        <= w_lfsr_nxt;
            r_active_rope <= w_active_rope_nxt;
            r_prev_rope   <= w_prev_rope_nxt;
            r_shock_pulse <= w_shock_pulse_nxt;
            r_shock_rope  <= w_shock_rope_nxt;
        end
    end

    // Per-rope status decode straight from the registered state.
    always_comb begin
        electroStatus = '0;
        for (int unsigned i = 0; i < ROPES; i++) begin
            if (3'(i) == r_active_rope) begin
                if (r_state == S_WARN) begin
                    electroStatus[2*i +: 2] = 2'b01;
                end else if (r_state == S_LIVE) begin
                    electroStatus[2*i +: 2] = 2'b10;
                end
            end
        end
    end

    assign liveN      = (r_state != S_LIVE);
    assign activeRope = r_active_rope;
    assign shockPulse = r_shock_pulse;
    assign shockRope  = r_shock_rope;

endmodule

// File: tb/tb_rope_electro_sequencer.sv
// Bench for rope_electro_sequencer: reference model plus pick/shock scoreboards.
module tb_rope_electro_sequencer;

    localparam int unsigned ROPES  = 6;
    localparam int unsigned IDLE_F = 2;
    localparam int unsigned WARN_F = 2;
    localparam int unsigned LIVE_F = 3;
    localparam logic [7:0]  SEED   = 8'hA5;
    localparam logic [19:0] RESET_VEC = 20'h00080;
    localparam int M_IDLE = 0;
    localparam int M_PICK = 1;
    localparam int M_WARN = 2;
    localparam int M_LIVE = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 startOfFrame;
    logic                 enable;
    logic [ROPES-1:0]     monkeyCollision;
    logic [ROPES*2-1:0]   electroStatus;
    logic [2:0]           activeRope;
    logic                 liveN;
    logic                 shockPulse;
    logic [2:0]           shockRope;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned tick     = 0;
    int unsigned sof_period = 10;

    int          m_state;
    int unsigned m_cnt, m_rope, m_prev, m_shock_rope;
    logic [7:0]  m_lfsr;
    logic        m_shock;
    int unsigned q_pick[$];
    int unsigned q_shock[$];

    rope_electro_sequencer #(
        .ROPES(ROPES), .IDLE_FRAMES(IDLE_F), .WARN_FRAMES(WARN_F),
        .LIVE_FRAMES(LIVE_F), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
        .monkeyCollision(monkeyCollision), .electroStatus(electroStatus),
        .activeRope(activeRope), .liveN(liveN), .shockPulse(shockPulse),
        .shockRope(shockRope)
    );

    always #5 clk = ~clk;

    // Reference model of the sequencer; predicted picks and shocks go to queues.
    always @(posedge clk) begin
        int unsigned r;
        if (reset) begin
            m_state <= M_IDLE; m_cnt <= 0; m_lfsr <= SEED; m_rope <= 0;
            m_prev <= ROPES - 1; m_shock <= 1'b0; m_shock_rope <= 0;
        end else begin
            m_lfsr  <= {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
            m_shock <= 1'b0;
            if (m_state != M_IDLE && !enable) begin
                m_state <= M_IDLE; m_cnt <= 0;
            end else begin
                case (m_state)
                    M_IDLE: if (enable && startOfFrame) begin
                        if (m_cnt == IDLE_F - 1) begin m_state <= M_PICK; m_cnt <= 0; end
                        else m_cnt <= m_cnt + 1;
                    end
                    M_PICK: begin
                        r = int'(m_lfsr) % 8;
                        if (r >= ROPES) r = r - ROPES;
                        if (r == m_prev) r = (r + 1) % ROPES;
                        m_rope <= r; m_prev <= r; q_pick.push_back(r);
                        m_state <= M_WARN;
                    end
                    M_WARN: if (startOfFrame) begin
                        if (m_cnt == WARN_F - 1) begin m_state <= M_LIVE; m_cnt <= 0; end
                        else m_cnt <= m_cnt + 1;
                    end
                    default: begin
                        if (monkeyCollision[m_rope]) begin
                            m_shock <= 1'b1; m_shock_rope <= m_rope; q_shock.push_back(m_rope);
                            m_state <= M_IDLE; m_cnt <= 0;
                        end else if (startOfFrame) begin
                            if (m_cnt == LIVE_F - 1) begin m_state <= M_IDLE; m_cnt <= 0; end
                            else m_cnt <= m_cnt + 1;
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic [19:0] exp_vec();
        logic [11:0] st;
        st = '0;
        if (m_state == M_WARN) st[2*m_rope +: 2] = 2'b01;
        else if (m_state == M_LIVE) st[2*m_rope +: 2] = 2'b10;
        return {st, (m_state != M_LIVE), 3'(m_rope), m_shock, 3'(m_shock_rope)};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {electroStatus, liveN, activeRope, shockPulse, shockRope};
    endfunction

    task automatic step();
        @(negedge clk);
        startOfFrame = ((tick % sof_period) == 0);
        tick++;
    endtask

    task automatic wait_for(input int st, input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget && !ok; i++) begin
            step();
            if (m_state == st) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; startOfFrame = 1'b0; monkeyCollision = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec(), RESET_VEC);
        end
        reset = 1'b0; tick = 0;
    endtask

    task automatic test_sequence();
        int unsigned warn_c = 0, live_c = 0;
        bit seen_live = 1'b0, done = 1'b0;
        enable = 1'b1; sof_period = 10;
        for (int unsigned i = 0; i < 200 && !done; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL seq_cycle t=%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (electroStatus != '0 && liveN) warn_c++;
            if (!liveN) begin live_c++; seen_live = 1'b1; end
            if (seen_live && liveN) done = 1'b1;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL seq_timeout: got done=0 expected 1"); end
        n_checks++;
        if (warn_c != 19) begin n_fail++; $display("FAIL seq_warn_len: got %0d expected 19", warn_c); end
        n_checks++;
        if (live_c != 30) begin n_fail++; $display("FAIL seq_live_len: got %0d expected 30", live_c); end
        n_checks++;
        if (electroStatus !== '0 || activeRope >= 3'(ROPES)) begin
            n_fail++; $display("FAIL seq_end: got status=%h rope=%0d expected 000 and rope<6", electroStatus, activeRope);
        end
    endtask

    task automatic test_pick_rule();
        int unsigned picks = 0, exp_r;
        bit prev_w = 1'b0, w;
        sof_period = 1; enable = 1'b1; monkeyCollision = '0;
        q_pick.delete();
        for (int unsigned i = 0; i < 1000; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL pick_cycle t=%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            w = (electroStatus != '0) && liveN;
            if (w && !prev_w) begin
                n_checks++;
                if (q_pick.size() == 0) begin
                    n_fail++; $display("FAIL pick_sb: got WARN with rope %0d expected no WARN", activeRope);
                end else begin
                    exp_r = q_pick.pop_front();
                    if (activeRope !== 3'(exp_r)) begin
                        n_fail++; $display("FAIL pick_sb: got rope %0d expected %0d", activeRope, exp_r);
                    end
                    picks++;
                end
            end
            prev_w = w;
        end
        n_checks++;
        if (picks < 100) begin n_fail++; $display("FAIL pick_count: got %0d expected >=100", picks); end
        sof_period = 10;
    endtask

    task automatic test_shock();
        bit ok; int unsigned rope, pulses = 0, exp_r;
        wait_for(M_LIVE, 300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL shock_wait: got no LIVE expected LIVE"); end
        rope = m_rope;
        monkeyCollision = ROPES'(1 << rope);
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL shock_cycle t=%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (shockPulse === 1'b1) begin
                pulses++;
                n_checks++;
                if (q_shock.size() == 0) begin
                    n_fail++; $display("FAIL shock_sb: got pulse rope %0d expected no pulse", shockRope);
                end else begin
                    exp_r = q_shock.pop_front();
                    if (shockRope !== 3'(exp_r) || exp_r != rope) begin
                        n_fail++; $display("FAIL shock_sb: got rope %0d expected %0d", shockRope, rope);
                    end
                end
            end
        end
        monkeyCollision = '0;
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL shock_count: got %0d expected 1", pulses); end
        n_checks++;
        if (liveN !== 1'b1 || electroStatus !== '0) begin
            n_fail++; $display("FAIL shock_idle: got liveN=%b status=%h expected 1 000", liveN, electroStatus);
        end
    endtask

    task automatic test_other_rope();
        bit ok; int unsigned live_c = 1, pulses = 0;
        wait_for(M_LIVE, 300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL other_wait: got no LIVE expected LIVE"); end
        monkeyCollision = ~ROPES'(1 << m_rope);
        for (int unsigned i = 0; i < 40; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL other_cycle t=%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (shockPulse === 1'b1) pulses++;
            if (liveN === 1'b0) live_c++;
            else break;
        end
        monkeyCollision = '0;
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL other_pulse: got %0d expected 0", pulses); end
        n_checks++;
        if (live_c != 30) begin n_fail++; $display("FAIL other_live_len: got %0d expected 30", live_c); end
    endtask

    task automatic test_coincident();
        bit found = 1'b0; int unsigned rope = 0, exp_r;
        for (int unsigned i = 0; i < 300 && !found; i++) begin
            step();
            if (m_state == M_LIVE && m_cnt == LIVE_F - 1 && startOfFrame) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL coinc_wait: got no last LIVE frame expected one"); end
        rope = m_rope;
        monkeyCollision = ROPES'(1 << rope);
        step();
        n_checks++;
        if (shockPulse !== 1'b1 || shockRope !== 3'(rope) || liveN !== 1'b1) begin
            n_fail++; $display("FAIL coinc_shock: got pulse=%b rope=%0d liveN=%b expected 1 %0d 1", shockPulse, shockRope, liveN, rope);
        end
        n_checks++;
        if (q_shock.size() == 0) begin
            n_fail++; $display("FAIL coinc_sb: got empty queue expected one entry");
        end else begin
            exp_r = q_shock.pop_front();
            if (shockRope !== 3'(exp_r)) begin
                n_fail++; $display("FAIL coinc_sb: got rope %0d expected %0d", shockRope, exp_r);
            end
        end
        step();
        monkeyCollision = '0;
        n_checks++;
        if (shockPulse !== 1'b0 || electroStatus !== '0) begin
            n_fail++; $display("FAIL coinc_single: got pulse=%b status=%h expected 0 000", shockPulse, electroStatus);
        end
    endtask

    task automatic test_disable();
        bit ok;
        wait_for(M_WARN, 300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL dis_wait: got no WARN expected WARN"); end
        enable = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (electroStatus !== '0 || liveN !== 1'b1 || dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL dis_warn: got %h expected %h with status 000", dut_vec(), exp_vec());
            end
        end
        enable = 1'b1;
        wait_for(M_LIVE, 300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL dis_wait_live: got no LIVE expected LIVE"); end
        enable = 1'b0;
        monkeyCollision = ROPES'(1 << m_rope);
        step();
        n_checks++;
        if (shockPulse !== 1'b0 || liveN !== 1'b1 || electroStatus !== '0) begin
            n_fail++; $display("FAIL dis_live: got pulse=%b liveN=%b status=%h expected 0 1 000", shockPulse, liveN, electroStatus);
        end
        monkeyCollision = '0;
        enable = 1'b1;
    endtask

    task automatic test_reset_live();
        bit ok, done = 1'b0; int unsigned exp_r;
        wait_for(M_LIVE, 300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rst_wait: got no LIVE expected LIVE"); end
        monkeyCollision = ROPES'(1 << m_rope);
        reset = 1'b1;
        step();
        n_checks++;
        if (dut_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL rst_live: got %h expected %h", dut_vec(), RESET_VEC);
        end
        reset = 1'b0;
        monkeyCollision = '0;
        q_pick.delete();
        for (int unsigned i = 0; i < 300 && !done; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rst_cycle t=%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (electroStatus != '0) done = 1'b1;
        end
        n_checks++;
        if (!done || q_pick.size() == 0) begin
            n_fail++; $display("FAIL rst_pick: got done=%b queued=%0d expected 1 and >=1", done, q_pick.size());
        end else begin
            exp_r = q_pick.pop_front();
            if (activeRope !== 3'(exp_r)) begin
                n_fail++; $display("FAIL rst_pick: got rope %0d expected %0d", activeRope, exp_r);
            end
        end
        n_checks++;
        if (q_shock.size() != 0) begin
            n_fail++; $display("FAIL shock_drain: got %0d leftover expected 0", q_shock.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequence();
        test_pick_rule();
        test_shock();
        test_other_rope();
        test_coincident();
        test_disable();
        test_reset_live();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
